// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: serialises data-cache refill reads and write-backs onto a
// single-beat, word-wide memory bus, with a one-entry write buffer.
// Build option: define WBUF_FWD_EN to serve reads that hit a buffered line
// write straight from the buffer instead of stalling behind the drain.
module cache_mem_bridge #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [2:0]        rd_type,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rdy,
  output logic              ret_valid,
  output logic              ret_last,
  output logic [31:0]       ret_data,
  input  logic              wr_req,
  input  logic [2:0]        wr_type,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_wstrb,
  input  logic [127:0]      wr_data,
  output logic              wr_rdy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_FWD} rd_state_e;
  typedef enum logic       {W_IDLE, W_BUSY} wr_state_e;

  rd_state_e         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_line_q, rd_line_d;
  logic [1:0]        beat_q, beat_d;
  logic              ret_valid_q, ret_valid_d;
  logic              ret_last_q, ret_last_d;
  logic [31:0]       ret_data_q, ret_data_d;

  wr_state_e         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] wbuf_addr_q, wbuf_addr_d;
  logic              wbuf_line_q, wbuf_line_d;
  logic [3:0]        wbuf_strb_q, wbuf_strb_d;
  logic [127:0]      wbuf_data_q, wbuf_data_d;
  logic [1:0]        wbeat_q, wbeat_d;

  // A request left on the bus without a grant keeps ownership so the
  // presented beat cannot change underneath the memory.
  logic              rd_hold_q, rd_hold_d;
  logic              wr_hold_q, wr_hold_d;

`ifdef WBUF_FWD_EN
  logic [127:0]      fwd_line_q, fwd_line_d;
`endif

  logic hazard, fwd_hit, rd_issue, wr_issue, rd_last, wr_last;
  logic unused_addr_bits;

  assign rd_rdy    = (rd_state_q == R_IDLE);
  assign wr_rdy    = (wr_state_q == W_IDLE);
  assign ret_valid = ret_valid_q;
  assign ret_last  = ret_last_q;
  assign ret_data  = ret_data_q;
  assign unused_addr_bits = ^{rd_addr_q[1:0], wbuf_addr_q[1:0]};

  // Hazard detection, bus arbitration and the presented memory beat.
  always_comb begin
    hazard = (rd_state_q == R_REQ) && (wr_state_q == W_BUSY) && !rd_hold_q &&
             (rd_addr_q[ADDR_W-1:4] == wbuf_addr_q[ADDR_W-1:4]);
`ifdef WBUF_FWD_EN
    fwd_hit = hazard && wbuf_line_q;
`else
    fwd_hit = 1'b0;
`endif
    rd_last   = !rd_line_q || (beat_q == 2'd3);
    wr_last   = !wbuf_line_q || (wbeat_q == 2'd3);
    rd_issue  = (rd_state_q == R_REQ) && !hazard && !wr_hold_q;
    wr_issue  = (wr_state_q == W_BUSY) && !rd_issue;
    mem_req   = rd_issue || wr_issue;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (rd_issue) begin
      mem_addr = rd_line_q ? {rd_addr_q[ADDR_W-1:4], beat_q, 2'b00}
                           : {rd_addr_q[ADDR_W-1:2], 2'b00};
    end else if (wr_issue) begin
      mem_we    = 1'b1;
      mem_addr  = wbuf_line_q ? {wbuf_addr_q[ADDR_W-1:4], wbeat_q, 2'b00}
                              : {wbuf_addr_q[ADDR_W-1:2], 2'b00};
      mem_wstrb = wbuf_line_q ? 4'hF : wbuf_strb_q;
      mem_wdata = wbuf_line_q ? wbuf_data_q[{wbeat_q, 5'd0} +: 32] : wbuf_data_q[31:0];
    end
    rd_hold_d = rd_issue && !mem_gnt;
    wr_hold_d = wr_issue && !mem_gnt;
  end

  // Read FSM: one outstanding beat, refill words returned through a register.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_addr_d   = rd_addr_q;
    rd_line_d   = rd_line_q;
    beat_d      = beat_q;
    ret_valid_d = 1'b0;
    ret_last_d  = 1'b0;
    ret_data_d  = ret_data_q;
`ifdef WBUF_FWD_EN
    fwd_line_d  = fwd_line_q;
`endif
    case (rd_state_q)
      R_IDLE: begin
        if (rd_req) begin
          rd_addr_d  = rd_addr;
          rd_line_d  = (rd_type == 3'b100);
          beat_d     = '0;
          rd_state_d = R_REQ;
        end
      end
      R_REQ: begin
        if (fwd_hit) begin
`ifdef WBUF_FWD_EN
          ret_valid_d = 1'b1;
          ret_last_d  = rd_last;
          ret_data_d  = wbuf_data_q[{(rd_line_q ? beat_q : rd_addr_q[3:2]), 5'd0} +: 32];
          fwd_line_d  = wbuf_data_q;
          beat_d      = 2'(beat_q + 2'd1);
          rd_state_d  = rd_last ? R_IDLE : R_FWD;
`endif
        end else if (rd_issue && mem_gnt) begin
          rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (mem_rvalid) begin
          ret_valid_d = 1'b1;
          ret_last_d  = rd_last;
          ret_data_d  = mem_rdata;
          beat_d      = 2'(beat_q + 2'd1);
          rd_state_d  = rd_last ? R_IDLE : R_REQ;
        end
      end
      default: begin
`ifdef WBUF_FWD_EN
        // Remaining forwarded words come from the snapshot so a buffer
        // refill during the burst cannot corrupt them.
        ret_valid_d = 1'b1;
        ret_last_d  = (beat_q == 2'd3);
        ret_data_d  = fwd_line_q[{beat_q, 5'd0} +: 32];
        beat_d      = 2'(beat_q + 2'd1);
        rd_state_d  = (beat_q == 2'd3) ? R_IDLE : R_FWD;
`else
        rd_state_d = R_IDLE;
`endif
      end
    endcase
  end

  // Write buffer FSM: capture in one cycle, drain beat by beat on grant.
  always_comb begin
    wr_state_d  = wr_state_q;
    wbuf_addr_d = wbuf_addr_q;
    wbuf_line_d = wbuf_line_q;
    wbuf_strb_d = wbuf_strb_q;
    wbuf_data_d = wbuf_data_q;
    wbeat_d     = wbeat_q;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_req) begin
          wbuf_addr_d = wr_addr;
          wbuf_line_d = (wr_type == 3'b100);
          wbuf_strb_d = wr_wstrb;
          wbuf_data_d = wr_data;
          wbeat_d     = '0;
          wr_state_d  = W_BUSY;
        end
      end
      default: begin
        if (wr_issue && mem_gnt) begin
          wbeat_d    = 2'(wbeat_q + 2'd1);
          wr_state_d = wr_last ? W_IDLE : W_BUSY;
        end
      end
    endcase
  end

  // State registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q  <= R_IDLE;
      rd_addr_q   <= '0;
      rd_line_q   <= 1'b0;
      beat_q      <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= '0;
      wr_state_q  <= W_IDLE;
      wbuf_addr_q <= '0;
      wbuf_line_q <= 1'b0;
      wbuf_strb_q <= '0;
      wbuf_data_q <= '0;
      wbeat_q     <= '0;
      rd_hold_q   <= 1'b0;
      wr_hold_q   <= 1'b0;
`ifdef WBUF_FWD_EN
      fwd_line_q  <= '0;
`endif
    end else begin
      rd_state_q  <= rd_state_d;
      rd_addr_q   <= rd_addr_d;
      rd_line_q   <= rd_line_d;
      beat_q      <= beat_d;
      ret_valid_q <= ret_valid_d;
      ret_last_q  <= ret_last_d;
      ret_data_q  <= ret_data_d;
      wr_state_q  <= wr_state_d;
      wbuf_addr_q <= wbuf_addr_d;
      wbuf_line_q <= wbuf_line_d;
      wbuf_strb_q <= wbuf_strb_d;
      wbuf_data_q <= wbuf_data_d;
      wbeat_q     <= wbeat_d;
      rd_hold_q   <= rd_hold_d;
      wr_hold_q   <= wr_hold_d;
`ifdef WBUF_FWD_EN
      fwd_line_q  <= fwd_line_d;
`endif
    end
  end

  // Beat sequencing is hard-wired for four-word lines.
  always_ff @(posedge clk) begin
    assert (LINE_WORDS == 4) else $error("cache_mem_bridge supports LINE_WORDS == 4 only");
  end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Scoreboard bench for cache_mem_bridge: a word-array memory model answers the
// bus, a reference memory predicts refill data, queues hold expected beats.
module tb_cache_mem_bridge;
  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req, wr_req, rd_rdy, wr_rdy;
  logic [2:0]   rd_type, wr_type;
  logic [31:0]  rd_addr, wr_addr, ret_data, mem_addr, mem_wdata, mem_rdata;
  logic         ret_valid, ret_last, mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]   wr_wstrb, mem_wstrb;
  logic [127:0] wr_data;

  always #5 clk = ~clk;

  cache_mem_bridge #(.ADDR_W(32), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct packed { logic last; logic [31:0] data; } ret_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wbeat_t;

  ret_t         ret_q[$];
  logic [31:0]  raddr_q[$];
  wbeat_t       wexp_q[$];
  bit           gnt_pat[$];
  logic [31:0]  ref_mem [int unsigned];
  logic [31:0]  bus_mem [int unsigned];
  int unsigned  n_cmp = 0, n_bad = 0, ret_seen = 0;
  logic [27:0]  cur_rd_line = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_unexp(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=unexpected beat required=none", name);
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return dflt(a);
  endfunction

  // Reference model: a write takes effect at acceptance, a read returns
  // memory as it stands at acceptance (after any same-cycle write).
  task automatic push_write_exp(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                                input logic [127:0] d);
    logic [31:0] wa;
    if (t == 3'b100) begin
      for (int i = 0; i < 4; i++) begin
        wa = {a[31:4], 4'(i * 4)};
        wexp_q.push_back('{addr: wa, data: d[32*i +: 32], strb: 4'hF});
        ref_mem[wa] = d[32*i +: 32];
      end
    end else begin
      wa = {a[31:2], 2'b00};
      wexp_q.push_back('{addr: wa, data: d[31:0], strb: s});
      ref_mem[wa] = merge(ref_rd(wa), d[31:0], s);
    end
  endtask

  task automatic push_read_exp(input logic [31:0] a, input logic [2:0] t);
    logic [31:0] ra;
    if (t == 3'b100) begin
      for (int i = 0; i < 4; i++) begin
        ra = {a[31:4], 4'(i * 4)};
        raddr_q.push_back(ra);
        ret_q.push_back('{last: (i == 3), data: ref_rd(ra)});
      end
    end else begin
      ra = {a[31:2], 2'b00};
      raddr_q.push_back(ra);
      ret_q.push_back('{last: 1'b1, data: ref_rd(ra)});
    end
  endtask

  // Called at a negedge; holds the requests for one cycle.
  task automatic drive(input bit rd, input logic [31:0] ra, input logic [2:0] rt,
                       input bit wr, input logic [31:0] wa, input logic [2:0] wt,
                       input logic [3:0] ws, input logic [127:0] wd);
    rd_req = rd; rd_addr = ra; rd_type = rt;
    wr_req = wr; wr_addr = wa; wr_type = wt; wr_wstrb = ws; wr_data = wd;
    if (wr && wr_rdy) push_write_exp(wa, wt, ws, wd);
    if (rd && rd_rdy) begin
      push_read_exp(ra, rt);
      cur_rd_line = ra[31:4];
    end
    @(negedge clk);
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned k = 0;
    while (k < 2000 && !(ret_q.size() == 0 && raddr_q.size() == 0 && wexp_q.size() == 0 &&
                         rd_rdy && wr_rdy)) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("%s_idle", name),
          {rd_rdy, wr_rdy, ret_q.size() == 0, raddr_q.size() == 0, wexp_q.size() == 0}, 5'b11111);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    ret_q.delete(); raddr_q.delete(); wexp_q.delete(); gnt_pat.delete();
    ref_mem = bus_mem;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Return-path monitor.
  initial begin : ret_monitor
    ret_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ret_valid) begin
          ret_seen++;
          if (ret_q.size() == 0) fail_unexp("ret_beat");
          else begin
            e = ret_q.pop_front();
            check("ret_data", ret_data, e.data);
            check("ret_last", ret_last, e.last);
          end
          if (!ret_last) check("rd_rdy_mid_line", rd_rdy, 1'b0);
        end else begin
          check("ret_last_idle", ret_last, 1'b0);
        end
      end
    end
  end

  // Memory bus model and bus-side checks.
  initial begin : mem_slave
    bit          rv_pend, prev_wait, g, clash;
    int unsigned rv_cnt;
    logic [31:0] rv_data;
    logic [69:0] saved;
    wbeat_t      w;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    rv_pend = 0; prev_wait = 0; rv_cnt = 0; rv_data = '0; saved = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; rv_pend = 0; prev_wait = 0;
      end else begin
        if (prev_wait) check("mem_hold", {mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata}, saved);
        mem_rvalid = 1'b0;
        if (rv_pend) begin
          if (rv_cnt == 0) begin
            mem_rvalid = 1'b1; mem_rdata = rv_data; rv_pend = 0;
          end else rv_cnt--;
        end
        g = 0;
        if (mem_req) begin
          if (gnt_pat.size() > 0) g = gnt_pat.pop_front();
          else g = ($urandom_range(0, 3) != 0);
          if (!mem_we) begin
            clash = 0;
            foreach (wexp_q[i]) if (wexp_q[i].addr[31:4] == mem_addr[31:4]) clash = 1;
            check("rd_behind_wr", clash, 1'b0);
          end
        end
        mem_gnt = g;
        if (g) begin
          if (mem_we) begin
            if (wexp_q.size() == 0) fail_unexp("wr_beat");
            else begin
              w = wexp_q.pop_front();
              check("wr_addr", mem_addr, w.addr);
              check("wr_data", mem_wdata, w.data);
              check("wr_strb", mem_wstrb, w.strb);
            end
            bus_mem[mem_addr] = merge(bus_rd(mem_addr), mem_wdata, mem_wstrb);
          end else begin
            if (raddr_q.size() == 0) fail_unexp("rd_beat");
            else check("rd_addr", mem_addr, raddr_q.pop_front());
            check("rd_outstanding", rv_pend, 1'b0);
            rv_pend = 1; rv_cnt = $urandom_range(0, 3); rv_data = bus_rd(mem_addr);
          end
        end
        prev_wait = mem_req && !g;
        saved = {mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata};
      end
    end
  end

  initial begin : stimulus
    int unsigned k;
    bit          rd, wr;
    logic [31:0] ra, wa;
    logic [2:0]  rt, wt;
    logic [3:0]  ws;
    logic [127:0] wd;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; rd_type = '0; wr_type = '0;
    rd_addr = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rd_rdy", rd_rdy, 1'b1);
    check("rst_wr_rdy", wr_rdy, 1'b1);
    check("rst_ret", {ret_valid, ret_last, ret_data}, '0);
    check("rst_mem", {mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata}, '0);

    drive(1, 32'h0000_1230, 3'b100, 0, '0, '0, '0, '0);
    wait_idle("line_rd");
    drive(1, 32'h0000_0088, 3'b010, 0, '0, '0, '0, '0);
    wait_idle("single_rd");
    gnt_pat = '{1, 0, 1, 1, 0, 1};
    drive(0, '0, '0, 1, 32'h400, 3'b100, 4'h0,
          {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000});
    wait_idle("line_wr");
    drive(0, '0, '0, 1, 32'h500, 3'b100, 4'h0,
          {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000});
    drive(1, 32'h500, 3'b100, 0, '0, '0, '0, '0);
    wait_idle("wr_then_rd");
    drive(0, '0, '0, 1, 32'h600, 3'b100, 4'h0,
          {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000});
    drive(1, 32'h700, 3'b100, 0, '0, '0, '0, '0);
    wait_idle("rd_vs_wr");
    drive(0, '0, '0, 1, 32'h88, 3'b001, 4'b0101, {96'h0, 32'hBEEF_CAFE});
    drive(1, 32'h80, 3'b100, 0, '0, '0, '0, '0);
    wait_idle("strb_wr_rd");

    k = ret_seen + 2;
    drive(1, 32'h1230, 3'b100, 1, 32'h800, 3'b100, 4'h0, {4{32'h8888_8888}});
    for (int i = 0; i < 200 && ret_seen < k; i++) @(negedge clk);
    check("beats_before_rst", ret_seen >= k, 1'b1);
    do_reset();
    check("midrst_rdy", {rd_rdy, wr_rdy}, 2'b11);
    check("midrst_ret_valid", ret_valid, 1'b0);
    check("midrst_mem_req", mem_req, 1'b0);

    for (int c = 0; c < 600; c++) begin
      ra = 32'h1000 + ($urandom_range(0, 7) << 4) + ($urandom_range(0, 3) << 2);
      wa = 32'h1000 + ($urandom_range(0, 7) << 4) + ($urandom_range(0, 3) << 2);
      rt = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 3));
      wt = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 3));
      ws = 4'($urandom_range(1, 15));
      wd = {$urandom, $urandom, $urandom, $urandom};
      rd = rd_rdy && ($urandom_range(0, 2) == 0);
      wr = wr_rdy && ($urandom_range(0, 2) == 0) && !(!rd_rdy && wa[31:4] == cur_rd_line);
      drive(rd, ra, rt, wr, wa, wt, ws, wd);
    end
    wait_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
